spi_obi_mem_slave: RTL and testbench

- Single-port, word-organised OBI slave memory that sits directly downstream of the SPI-slave OBI master plug and services its request/response traffic.
- Used as the on-chip target in SPI-to-memory subsystems and as the reference target in the SPI slave testbench.
- Configurable grant wait and response latency let us exercise the plug's OBIADDR and OBIRESP stall paths.
- Supports one outstanding transaction; per-byte write enables; error response for out-of-range addresses.

---
 rtl/spi_obi_mem_slave.sv | 191 +++++++++++++++++++
 tb/tb_spi_obi_mem_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_obi_mem_slave.sv
// -----------------------------------------------------------------------------
// spi_obi_mem_slave
//
// Single-port, word-organised OBI slave memory. It is the downstream target of
// the SPI-slave OBI master plug. Only one transaction can be outstanding.
// The grant wait and the response latency are programmable, so the plug's
// address-phase and response-phase stall paths can be exercised.
//
// Ports
//   obi_aclk           clock
//   obi_areset         synchronous, active-high reset
//   obi_slave_req      request; a transfer is accepted when req && gnt
//   obi_slave_gnt      grant (combinational from state, counter and req)
//   obi_slave_addr     byte address; bits [1:0] are ignored
//   obi_slave_we       1 = write, 0 = read
//   obi_slave_be       per-byte write enables
//   obi_slave_w_data   write data
//   obi_slave_r_valid  response valid; held until r_ready
//   obi_slave_r_ready  response accept
//   obi_slave_r_data   read data (0 for writes and for out-of-range reads)
//   obi_slave_err      out-of-range flag; only meaningful with r_valid
// -----------------------------------------------------------------------------
module spi_obi_mem_slave #(
  parameter int                        OBI_ADDR_WIDTH = 32,
  parameter int                        OBI_DATA_WIDTH = 32,
  parameter int                        MEM_WORDS      = 1024,
  parameter logic [OBI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        GNT_WAIT       = 1,
  parameter int                        RESP_LAT       = 1
) (
  input  logic                      obi_aclk,
  input  logic                      obi_areset,
  input  logic                      obi_slave_req,
  output logic                      obi_slave_gnt,
  input  logic [OBI_ADDR_WIDTH-1:0] obi_slave_addr,
  input  logic                      obi_slave_we,
  input  logic [3:0]                obi_slave_be,
  input  logic [OBI_DATA_WIDTH-1:0] obi_slave_w_data,
  output logic                      obi_slave_r_valid,
  input  logic                      obi_slave_r_ready,
  output logic [OBI_DATA_WIDTH-1:0] obi_slave_r_data,
  output logic                      obi_slave_err
);

  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(MEM_WORDS);
  // One extra bit so the byte size of the memory never wraps.
  localparam logic [OBI_ADDR_WIDTH:0] MEM_BYTES = (OBI_ADDR_WIDTH+1)'(4 * MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
  // The accept edge itself accounts for one cycle of latency, so the LAT
  // counter is loaded with RESP_LAT-2 and RESP_LAT==1 skips LAT entirely.
  localparam logic [3:0] LAT_LOAD  = 4'((RESP_LAT > 1) ? RESP_LAT - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_LAT,
    ST_RESP
  } state_t;

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [3:0]  lat_cnt_reg;
  logic        r_valid_reg;
  logic        err_reg;
  logic        rd_ok_reg;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [OBI_ADDR_WIDTH-1:0] offset;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic                      unused_offset_bits;

  assign offset   = obi_slave_addr - BASE_ADDR;
  assign in_range = (obi_slave_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign idx      = offset[IDX_W+1:2];
  assign unused_offset_bits = ^offset;

  // ---------------------------------------------------------------------------
  // Grant: gated by reset so nothing is accepted in a reset cycle.
  // ---------------------------------------------------------------------------
  logic accept;
  logic wr_en;
  logic rd_en;

  always_comb begin
    obi_slave_gnt = 1'b0;
    case (state_reg)
      ST_IDLE:     obi_slave_gnt = obi_slave_req && (GNT_WAIT == 0);
      ST_WAIT_GNT: obi_slave_gnt = obi_slave_req && (wait_cnt_reg == 4'd0);
      default:     obi_slave_gnt = 1'b0;
    endcase
    if (obi_areset) begin
      obi_slave_gnt = 1'b0;
    end
  end

  assign accept = obi_slave_req && obi_slave_gnt;
  assign wr_en  = accept && obi_slave_we && in_range;
  assign rd_en  = accept && !obi_slave_we && in_range;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane, each with a registered read port.
  // The read register samples the word before the same-edge write lands.
  // ---------------------------------------------------------------------------
  logic [OBI_DATA_WIDTH-1:0] rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] mem [MEM_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge obi_aclk) begin
        if (wr_en && obi_slave_be[gi]) begin
          mem[idx] <= obi_slave_w_data[8*gi +: 8];
        end
        if (rd_en) begin
          rd_byte_reg <= mem[idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge obi_aclk) begin
    if (obi_areset) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      lat_cnt_reg  <= 4'd0;
      r_valid_reg  <= 1'b0;
      err_reg      <= 1'b0;
      rd_ok_reg    <= 1'b0;
    end else begin
      if (accept) begin
        err_reg   <= !in_range;
        rd_ok_reg <= rd_en;
        if (RESP_LAT <= 1) begin
          state_reg   <= ST_RESP;
          r_valid_reg <= 1'b1;
        end else begin
          state_reg   <= ST_LAT;
          lat_cnt_reg <= LAT_LOAD;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (obi_slave_req) begin
              wait_cnt_reg <= WAIT_LOAD;
              state_reg    <= ST_WAIT_GNT;
            end
          end
          ST_WAIT_GNT: begin
            // A dropped request is a protocol violation; just start over.
            if (!obi_slave_req) begin
              state_reg <= ST_IDLE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end
          end
          ST_LAT: begin
            if (lat_cnt_reg == 4'd0) begin
              state_reg   <= ST_RESP;
              r_valid_reg <= 1'b1;
            end else begin
              lat_cnt_reg <= lat_cnt_reg - 4'd1;
            end
          end
          ST_RESP: begin
            if (obi_slave_r_ready) begin
              state_reg   <= ST_IDLE;
              r_valid_reg <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign obi_slave_r_valid = r_valid_reg;
  assign obi_slave_err     = err_reg;
  assign obi_slave_r_data  = rd_ok_reg ? rd_word : '0;

endmodule

// File: tb/tb_spi_obi_mem_slave.sv
// -----------------------------------------------------------------------------
// Testbench for spi_obi_mem_slave. Two instances share one stimulus bus:
//   dut_a: GNT_WAIT=1, RESP_LAT=1, BASE=0x1000, 1024 words
//   dut_b: GNT_WAIT=0, RESP_LAT=3, BASE=0x0000, 16 words
// sel chooses which instance sees req and drives the observed outputs.
// -----------------------------------------------------------------------------
module tb_spi_obi_mem_slave;

  localparam logic [31:0] BASE_A  = 32'h0000_1000;
  localparam int          WORDS_A = 1024;
  localparam logic [31:0] BASE_B  = 32'h0000_0000;
  localparam int          WORDS_B = 16;

  logic        clk = 1'b0;
  logic        areset;
  logic        sel;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        r_ready;

  logic        gnt_a, gnt_b, r_valid_a, r_valid_b, err_a, err_b;
  logic [31:0] r_data_a, r_data_b;
  logic        gnt, r_valid, err;
  logic [31:0] r_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_obi_mem_slave #(
    .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MEM_WORDS(WORDS_A),
    .BASE_ADDR(BASE_A), .GNT_WAIT(1), .RESP_LAT(1)
  ) dut_a (
    .obi_aclk(clk), .obi_areset(areset),
    .obi_slave_req(req && !sel), .obi_slave_gnt(gnt_a),
    .obi_slave_addr(addr), .obi_slave_we(we), .obi_slave_be(be),
    .obi_slave_w_data(wdata), .obi_slave_r_valid(r_valid_a),
    .obi_slave_r_ready(r_ready), .obi_slave_r_data(r_data_a),
    .obi_slave_err(err_a)
  );

  spi_obi_mem_slave #(
    .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MEM_WORDS(WORDS_B),
    .BASE_ADDR(BASE_B), .GNT_WAIT(0), .RESP_LAT(3)
  ) dut_b (
    .obi_aclk(clk), .obi_areset(areset),
    .obi_slave_req(req && sel), .obi_slave_gnt(gnt_b),
    .obi_slave_addr(addr), .obi_slave_we(we), .obi_slave_be(be),
    .obi_slave_w_data(wdata), .obi_slave_r_valid(r_valid_b),
    .obi_slave_r_ready(r_ready), .obi_slave_r_data(r_data_b),
    .obi_slave_err(err_b)
  );

  assign gnt     = sel ? gnt_b     : gnt_a;
  assign r_valid = sel ? r_valid_b : r_valid_a;
  assign r_data  = sel ? r_data_b  : r_data_a;
  assign err     = sel ? err_b     : err_a;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds req until gnt is seen (sampled mid-cycle); n = cycles waited.
  task automatic wait_gnt(output int n);
    n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input string name, input logic t_we, input logic [31:0] t_addr,
                         input logic [3:0] t_be, input logic [31:0] t_wdata,
                         input int exp_wait, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata; r_ready = 1'b1;
    wait_gnt(n);
    check({name, " gnt_wait"}, n, exp_wait);
    @(posedge clk); #1;            // accept edge
    req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!r_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " r_data"}, r_data, exp_rdata);
    check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    $display("txn %s we=%0d addr=%h be=%h wdata=%h r_data=%h err=%0d wait=%0d lat=%0d",
             name, t_we, t_addr, t_be, t_wdata, r_data, err, n, lat);
    @(posedge clk); #1;            // handshake edge
  endtask

  initial begin
    int n;
    logic [31:0] held_data;

    vecs[0]  = '{1'b1, BASE_A + 32'h10, 4'hF, 32'hA5A5_1234, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, BASE_A + 32'h10, 4'hF, 32'h0,         32'hA5A5_1234, 1'b0};
    vecs[2]  = '{1'b1, BASE_A + 32'h14, 4'hF, 32'h1234_5678, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, BASE_A + 32'h14, 4'h3, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, BASE_A + 32'h14, 4'hF, 32'h0,         32'h1234_FFFF, 1'b0};
    vecs[5]  = '{1'b1, BASE_A,          4'hF, 32'h0BAD_F00D, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, BASE_A + 32'h1000, 4'hF, 32'h0,       32'h0, 1'b1};
    vecs[7]  = '{1'b1, BASE_A + 32'h1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, BASE_A,          4'hF, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[9]  = '{1'b0, BASE_A - 32'h4,  4'hF, 32'h0,         32'h0, 1'b1};
    vecs[10] = '{1'b0, BASE_A + 32'h17, 4'hF, 32'h0,         32'h1234_FFFF, 1'b0};
    vecs[11] = '{1'b1, BASE_A + 32'hFFC, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
    vecs[12] = '{1'b0, BASE_A + 32'hFFC, 4'hF, 32'h0,        32'h1122_3344, 1'b0};

    areset = 1'b1; sel = 1'b0; req = 1'b1; addr = BASE_A; we = 1'b0;
    be = 4'hF; wdata = '0; r_ready = 1'b1;

    // Reset state, with req high to show reset blocks the grant.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset gnt", {31'd0, gnt}, 32'd0);
    check("reset r_valid", {31'd0, r_valid}, 32'd0);
    check("reset r_data", r_data, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0; req = 1'b0;
    @(posedge clk); #1;

    // Directed table on dut_a.
    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("a_vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be,
              vecs[i].wdata, 1, 1, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-pressure: r_ready low for 5 RESP cycles with req kept high.
    req = 1'b1; we = 1'b0; addr = BASE_A + 32'h10; be = 4'hF; r_ready = 1'b0;
    wait_gnt(n);
    check("stall gnt_wait", n, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall r_valid c%0d", k), {31'd0, r_valid}, 32'd1);
      check($sformatf("stall r_data c%0d", k), r_data, 32'hA5A5_1234);
      check($sformatf("stall err c%0d", k), {31'd0, err}, 32'd0);
      check($sformatf("stall gnt c%0d", k), {31'd0, gnt}, 32'd0);
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    @(negedge clk);
    check("stall r_valid at handshake", {31'd0, r_valid}, 32'd1);
    check("stall gnt at handshake", {31'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-handshake gnt", {31'd0, gnt}, 32'd0);
    check("post-handshake r_valid", {31'd0, r_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("regrant gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    held_data = r_data;
    check("regrant r_valid", {31'd0, r_valid}, 32'd1);
    check("regrant r_data", held_data, 32'hA5A5_1234);
    $display("txn stall_read addr=%h r_data=%h err=%0d", addr, held_data, err);
    @(posedge clk); #1;

    // Reset during RESP after a committed write.
    req = 1'b1; we = 1'b1; addr = BASE_A + 32'h20; be = 4'hF; wdata = 32'h0000_00C3;
    r_ready = 1'b0;
    wait_gnt(n);
    check("rst_resp gnt_wait", n, 1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("rst_resp r_valid before", {31'd0, r_valid}, 32'd1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    check("rst_resp r_valid after", {31'd0, r_valid}, 32'd0);
    check("rst_resp gnt after", {31'd0, gnt}, 32'd0);
    $display("txn rst_in_resp addr=%h r_valid=%0d gnt=%0d", addr, r_valid, gnt);
    @(posedge clk); #1;
    r_ready = 1'b1;
    run_txn("a_read_after_rst", 1'b0, BASE_A + 32'h20, 4'hF, 32'h0, 1, 1, 32'h0000_00C3, 1'b0);

    // Plug-style stream on dut_b: zero grant wait, three-cycle latency.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("b_wr%0d", i), 1'b1, BASE_B + 32'(4 * i), 4'hF,
              32'(i) * 32'h1111_1111, 0, 3, 32'h0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("b_rd%0d", i), 1'b0, BASE_B + 32'(4 * i), 4'hF, 32'h0,
              0, 3, 32'(i) * 32'h1111_1111, 1'b0);
    end
    run_txn("b_oor", 1'b0, BASE_B + 32'(4 * WORDS_B), 4'hF, 32'h0, 0, 3, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
